regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 89 ++++++++
 tb/tb_regfile_mp.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-enabled write, write-first bypass and a sequential clear.
// Reads are combinational with zero latency; writes land on the next edge; writes are dropped while busy.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wbe,
   input  logic                  is_overflow,
   input  logic [NRD*ADDR_W-1:0] raddr,
   output logic [NRD*DATA_W-1:0] rdata,
   input  logic                  clr_req,
   output logic                  busy
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int NB    = DATA_W/8;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   mem_d [DEPTH];
   logic                wr_eff;
   logic [DATA_W-1:0]   wmerge;

   // A clear request in the same cycle takes priority over the write.
   always_comb begin
      wr_eff = we && !is_overflow && (state_q == IDLE) && !clr_req && rst_n &&
               ((ZERO_REG == 0) || (waddr != '0));
      wmerge = mem_q[waddr];
      for (int i = 0; i < NB; i++) begin
         if (wbe[i]) wmerge[8*i +: 8] = wdata[8*i +: 8];
      end
   end

   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;
      assign ra = raddr[k*ADDR_W +: ADDR_W];
      always_comb begin
         rd = mem_q[ra];
         if (!rst_n || (state_q == CLEAR)) rd = '0;
         else if ((ZERO_REG != 0) && (ra == '0)) rd = '0;
         else if (wr_eff && (ra == waddr)) rd = wmerge;
      end
      assign rdata[k*DATA_W +: DATA_W] = rd;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mem_d   = mem_q;
      if (state_q == IDLE) begin
         if (clr_req) begin
            state_d = CLEAR;
            cnt_d   = '0;
         end else if (wr_eff) begin
            mem_d[waddr] = wmerge;
         end
      end else begin
         mem_d[cnt_q] = '0;
         cnt_d        = cnt_q + ADDR_W'(1);
         if (cnt_q == {ADDR_W{1'b1}}) state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      end
   end

   assign busy = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: expected read data queued as addresses are driven, popped when sampled.
module tb_regfile_mp;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int NRD   = 2;
   localparam int DEPTH = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              we = 1'b0;
   logic [AW-1:0]     waddr = '0;
   logic [DW-1:0]     wdata = '0;
   logic [DW/8-1:0]   wbe = '0;
   logic              is_overflow = 1'b0;
   logic [NRD*AW-1:0] raddr = '0;
   logic [NRD*DW-1:0] rdata;
   logic              clr_req = 1'b0;
   logic              busy;

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .ZERO_REG(1)) dut (
      .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .is_overflow(is_overflow), .raddr(raddr), .rdata(rdata), .clr_req(clr_req), .busy(busy)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] model [DEPTH];
   logic [31:0] exp_q [$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] got);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         check_val({tag, "_noexp"}, got, 32'hxxxx_xxxx ^ got ^ 32'h1);
      end else begin
         e = exp_q.pop_front();
         check_val(tag, got, e);
      end
   endtask

   task automatic rd2(input string tag, input logic [AW-1:0] a0, input logic [31:0] e0,
                      input logic [AW-1:0] a1, input logic [31:0] e1);
      raddr[0 +: AW]  = a0;
      raddr[AW +: AW] = a1;
      exp_q.push_back(e0);
      exp_q.push_back(e1);
      #1;
      pop_chk({tag, "_p0"}, rdata[0 +: DW]);
      pop_chk({tag, "_p1"}, rdata[DW +: DW]);
   endtask

   task automatic rd_model(input string tag, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd2(tag, a0, model[a0], a1, model[a1]);
   endtask

   // Drives one write cycle, checks the same-cycle bypass on both ports, then updates the model.
   task automatic wr(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic ovf);
      logic [31:0] nxt;
      logic [31:0] e;
      nxt = model[a];
      for (int i = 0; i < 4; i++) if (be[i]) nxt[8*i +: 8] = d[8*i +: 8];
      e = (a == 0) ? 32'h0 : (ovf ? model[a] : nxt);
      @(negedge clk);
      we = 1'b1; waddr = a; wdata = d; wbe = be; is_overflow = ovf;
      rd2({tag, "_byp"}, a, e, a, e);
      @(posedge clk);
      if (!ovf && a != 0) model[a] = nxt;
      #1;
      we = 1'b0; is_overflow = 1'b0;
   endtask

   int cycles;

   initial begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;

      // Reset: reads are zero even with a would-be bypassing write present
      @(negedge clk);
      we = 1'b1; waddr = 5'd5; wdata = 32'hFFFF_FFFF; wbe = 4'hF; clr_req = 1'b1;
      rd2("rst_rd", 5'd5, 32'h0, 5'd0, 32'h0);
      check_val("rst_busy", {31'b0, busy}, 32'h0);
      @(negedge clk);
      we = 1'b0; clr_req = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_val("rst_busy_rel", {31'b0, busy}, 32'h0);

      // Basic write path and hardwired zero register
      wr("w5", 5'd5, 32'hDEAD_BEEF, 4'hF, 1'b0);
      rd2("r5", 5'd5, 32'hDEAD_BEEF, 5'd5, 32'hDEAD_BEEF);
      wr("w0", 5'd0, 32'h1234_5678, 4'hF, 1'b0);
      rd2("r0", 5'd0, 32'h0, 5'd0, 32'h0);

      // Byte enables with bypass
      wr("w7", 5'd7, 32'h1122_3344, 4'hF, 1'b0);
      wr("be", 5'd7, 32'hAABB_CCDD, 4'b0101, 1'b0);
      rd2("be_st", 5'd7, 32'h11BB_33DD, 5'd5, 32'hDEAD_BEEF);
      wr("be0", 5'd7, 32'hFFFF_FFFF, 4'h0, 1'b0);
      rd2("be0_st", 5'd7, 32'h11BB_33DD, 5'd7, 32'h11BB_33DD);

      // Overflow cancels the write
      wr("w3", 5'd3, 32'h5, 4'hF, 1'b0);
      wr("ovf", 5'd3, 32'hFFFF_FFFF, 4'hF, 1'b1);
      rd2("ovf_st", 5'd3, 32'h5, 5'd3, 32'h5);

      // Mixed random traffic, independent port addresses
      for (int i = 0; i < 8; i++)
         wr("rnd", 5'($urandom_range(1, 31)), $urandom, 4'($urandom_range(0, 15)), 1'b0);
      for (int i = 0; i < 6; i++)
         rd_model("rnd_rd", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

      // Clear with a colliding write to r9
      wr("w9", 5'd9, 32'h0000_0099, 4'hF, 1'b0);
      @(negedge clk);
      clr_req = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'hCAFE_F00D; wbe = 4'hF;
      rd2("coll_byp", 5'd9, 32'h0000_0099, 5'd9, 32'h0000_0099);
      @(posedge clk); #1;
      clr_req = 1'b0; we = 1'b0;
      check_val("clr_busy", {31'b0, busy}, 32'h1);
      cycles = 0;
      while (busy && cycles < 100) begin
         @(negedge clk);
         if (cycles == 3) begin
            we = 1'b1; waddr = 5'd12; wdata = 32'h1212_1212; wbe = 4'hF;
            rd2("clr_rd", 5'd12, 32'h0, 5'd5, 32'h0);
         end
         if (cycles == 10) clr_req = 1'b1;
         @(posedge clk); #1;
         we = 1'b0; clr_req = 1'b0;
         cycles++;
      end
      check_val("clr_len", 32'(cycles), 32'd32);
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      for (int i = 0; i < DEPTH; i++) rd_model("clr_all", 5'(i), 5'(DEPTH - 1 - i));

      // Async reset in the middle of a clear
      wr("w20", 5'd20, 32'h2020_2020, 4'hF, 1'b0);
      wr("w5b", 5'd5, 32'h5555_5555, 4'hF, 1'b0);
      @(negedge clk);
      clr_req = 1'b1;
      @(posedge clk); #1;
      clr_req = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_busy", {31'b0, busy}, 32'h0);
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      rd2("arst_rd", 5'd20, 32'h0, 5'd5, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_val("arst_idle", {31'b0, busy}, 32'h0);
      rd_model("arst_post", 5'd20, 5'd31);
      wr("post_wr", 5'd20, 32'h0000_1234, 4'hF, 1'b0);
      rd_model("post_rd", 5'd20, 5'd5);
      check_val("post_busy", {31'b0, busy}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
